// File: rtl/input_conditioner.sv
// Synchronises, debounces and press-detects the DE1-SoC pushbuttons and slider switches.
// Sticky press flags and the interrupt are built only when INPUT_COND_EDGE_IRQ_EN is defined.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic [9:0] sw,
    output logic [3:0] pushbuttons_export,
    output logic [9:0] slider_switches_export,
    output logic [3:0] key_press,
    output logic [3:0] key_edge,
    input  logic [3:0] edge_clear,
    input  logic [3:0] irq_mask,
    output logic       irq
);
    localparam int NCH = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   raw_p0;
    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   stable;
    logic [CNT_W-1:0] cnt [NCH];
    logic [3:0]       key_stable_p1;
    logic [3:0]       key_rise;

    // Keys are inverted up front so every channel is active-high from here on.
    assign raw_p0 = {sw, ~key_n};

    // Synchroniser stage
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_p0;
            s2 <= s1;
        end
    end

    // Debounce stage: any return to the stable level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pushbuttons_export     = stable[3:0];
    assign slider_switches_export = stable[13:4];

    // Press-detect stage
    assign key_rise = stable[3:0] & ~key_stable_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_stable_p1 <= '0;
            key_press     <= '0;
        end else begin
            key_stable_p1 <= stable[3:0];
            key_press     <= key_rise;
        end
    end

`ifdef INPUT_COND_EDGE_IRQ_EN
    // Flag stage: a new press outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_edge <= '0;
            irq      <= 1'b0;
        end else begin
            key_edge <= (key_edge & ~edge_clear) | key_rise;
            irq      <= |(key_edge & irq_mask);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{edge_clear, irq_mask};
    assign key_edge   = '0;
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (DEBOUNCE_CYCLES=4) with an edge-indexed scoreboard.
module tb_input_conditioner;
    localparam int DB      = 4;
    localparam int SIG_PB  = 0;
    localparam int SIG_SW  = 1;
    localparam int SIG_KP  = 2;
    localparam int SIG_KE  = 3;
    localparam int SIG_IRQ = 4;

`ifdef INPUT_COND_EDGE_IRQ_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic [3:0] key_n      = 4'hF;
    logic [9:0] sw         = '0;
    logic [3:0] edge_clear = '0;
    logic [3:0] irq_mask   = '0;
    logic [3:0] pushbuttons_export;
    logic [9:0] slider_switches_export;
    logic [3:0] key_press;
    logic [3:0] key_edge;
    logic       irq;

    typedef struct {
        int         at;
        int         sig;
        logic [9:0] val;
    } exp_t;

    exp_t       sb[$];
    int         edge_cnt = 0;
    int         checks   = 0;
    int         failures = 0;
    logic [9:0] obs;

    input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .key_n                  (key_n),
        .sw                     (sw),
        .pushbuttons_export     (pushbuttons_export),
        .slider_switches_export (slider_switches_export),
        .key_press              (key_press),
        .key_edge               (key_edge),
        .edge_clear             (edge_clear),
        .irq_mask               (irq_mask),
        .irq                    (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [9:0] observe(input int sig);
        case (sig)
            SIG_PB:  return {6'b0, pushbuttons_export};
            SIG_SW:  return slider_switches_export;
            SIG_KP:  return {6'b0, key_press};
            SIG_KE:  return {6'b0, key_edge};
            default: return {9'b0, irq};
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_PB:  return "pushbuttons_export";
            SIG_SW:  return "slider_switches_export";
            SIG_KP:  return "key_press";
            SIG_KE:  return "key_edge";
            default: return "irq";
        endcase
    endfunction

    function automatic logic [9:0] ke_exp(input logic [3:0] v);
        return EDGE_EN ? {6'b0, v} : 10'h0;
    endfunction

    function automatic logic [9:0] irq_exp(input logic v);
        return EDGE_EN ? {9'b0, v} : 10'h0;
    endfunction

    // Outputs are sampled on the falling edge, after edge number edge_cnt.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == edge_cnt) begin
                obs = observe(sb[i].sig);
                checks++;
                assert (obs === sb[i].val) else begin
                    failures++;
                    $error("FAIL %s edge=%0d observed=%h expected=%h",
                           sig_name(sb[i].sig), edge_cnt, obs, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int at, input int sig, input logic [9:0] val);
        exp_t e;
        e.at  = at;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic expect_all_zero(input int at);
        for (int s = SIG_PB; s <= SIG_IRQ; s++) expect_at(at, s, 10'h0);
    endtask

    // Press first sampled at edge n, with no keys debounced and no flags set beforehand.
    task automatic check_press(input int n, input logic [3:0] keys, input logic [3:0] mask);
        expect_at(n + 4, SIG_PB, 10'h0);
        expect_at(n + 5, SIG_PB, {6'b0, keys});
        expect_at(n + 5, SIG_KP, 10'h0);
        expect_at(n + 6, SIG_KP, {6'b0, keys});
        expect_at(n + 7, SIG_KP, 10'h0);
        expect_at(n + 5, SIG_KE, 10'h0);
        expect_at(n + 6, SIG_KE, ke_exp(keys));
        expect_at(n + 6, SIG_IRQ, 10'h0);
        expect_at(n + 7, SIG_IRQ, irq_exp(|(keys & mask)));
    endtask

    task automatic release_and_clear(input logic [3:0] keys);
        int n;
        key_n = 4'hF;
        n = edge_cnt + 1;
        expect_at(n + 4, SIG_PB, {6'b0, keys});
        expect_at(n + 5, SIG_PB, 10'h0);
        for (int i = 0; i <= 8; i++) expect_at(n + i, SIG_KP, 10'h0);
        repeat (10) @(negedge clk);
        edge_clear = 4'hF;
        n = edge_cnt + 1;
        expect_at(n, SIG_KE, 10'h0);
        expect_at(n + 1, SIG_IRQ, 10'h0);
        @(negedge clk);
        edge_clear = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        // Reset held, then idle with all inputs released.
        @(negedge clk);
        expect_all_zero(edge_cnt + 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) expect_all_zero(edge_cnt + i);
        repeat (10) @(negedge clk);

        // Single press on key 0 with its interrupt enabled.
        irq_mask = 4'h1;
        key_n    = 4'hE;
        check_press(edge_cnt + 1, 4'h1, 4'h1);
        repeat (10) @(negedge clk);
        release_and_clear(4'h1);

        // Reset in the middle of a count, then the full latency again.
        key_n = 4'hE;
        n = edge_cnt + 1;
        for (int i = 0; i <= 7; i++) begin
            expect_at(n + i, SIG_PB, 10'h0);
            expect_at(n + i, SIG_KP, 10'h0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_press(edge_cnt + 1, 4'h1, 4'h1);
        repeat (10) @(negedge clk);
        release_and_clear(4'h1);

        // sw[9]: a 3-sample pulse is filtered, a 4-sample pulse gets through.
        sw[9] = 1'b1;
        n = edge_cnt + 1;
        for (int i = 0; i <= 12; i++) expect_at(n + i, SIG_SW, 10'h0);
        repeat (3) @(negedge clk);
        sw[9] = 1'b0;
        repeat (10) @(negedge clk);
        sw[9] = 1'b1;
        n = edge_cnt + 1;
        expect_at(n + 4, SIG_SW, 10'h000);
        for (int i = 5; i <= 8; i++) expect_at(n + i, SIG_SW, 10'h200);
        expect_at(n + 9, SIG_SW, 10'h000);
        repeat (4) @(negedge clk);
        sw[9] = 1'b0;
        repeat (10) @(negedge clk);

        // sw[3] chattering every 2 cycles never settles.
        n = edge_cnt + 1;
        for (int i = 0; i <= 44; i++) expect_at(n + i, SIG_SW, 10'h0);
        for (int k = 0; k < 20; k++) begin
            sw[3] = ~sw[3];
            repeat (2) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        // Key 2: flag set, then a clear coinciding with a new press, then clear alone.
        irq_mask = 4'h4;
        key_n    = 4'hB;
        check_press(edge_cnt + 1, 4'h4, 4'h4);
        repeat (10) @(negedge clk);
        key_n = 4'hF;
        n = edge_cnt + 1;
        expect_at(n + 5, SIG_PB, 10'h0);
        expect_at(n + 5, SIG_KE, ke_exp(4'h4));
        expect_at(n + 5, SIG_IRQ, irq_exp(1'b1));
        repeat (10) @(negedge clk);
        key_n = 4'hB;
        n = edge_cnt + 1;
        expect_at(n + 5, SIG_PB, 10'h4);
        expect_at(n + 5, SIG_KE, ke_exp(4'h4));
        expect_at(n + 6, SIG_KP, 10'h4);
        expect_at(n + 7, SIG_KP, 10'h0);
        repeat (6) @(negedge clk);
        edge_clear = 4'h4;
        expect_at(n + 6, SIG_KE, ke_exp(4'h4));
        expect_at(n + 7, SIG_KE, 10'h0);
        expect_at(n + 7, SIG_IRQ, irq_exp(1'b1));
        expect_at(n + 8, SIG_IRQ, 10'h0);
        repeat (2) @(negedge clk);
        edge_clear = 4'h0;
        repeat (5) @(negedge clk);
        release_and_clear(4'h4);

        // Keys 1 and 3 together, interrupts masked off.
        irq_mask = 4'h0;
        key_n    = 4'h5;
        check_press(edge_cnt + 1, 4'hA, 4'h0);
        repeat (10) @(negedge clk);
        release_and_clear(4'hA);

        repeat (3) @(negedge clk);
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronises, debounces and edge-detects the DE1-SoC board pushbuttons and slider switches before they reach the system's `pushbuttons_export` and `slider_switches_export` PIO inputs, one stage upstream of them. The raw pushbutton inputs are active-low; this block drives the PIO inputs active-high. It also provides per-key press pulses and, optionally, sticky press-capture flags with an interrupt for logic outside the processor system.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles a synchronised input must differ from its debounced value before that value is updated (1 ms at 50 MHz). Legal range ≥1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of each debounce counter.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `key_n`  in  4  raw pushbuttons, active-low, asynchronous.
- `sw`  in  10  raw slider switches, active-high, asynchronous.
- `pushbuttons_export`  out  4  debounced pushbuttons, active-high (1 = pressed).
- `slider_switches_export`  out  10  debounced switches.
- `key_press`  out  4  one-cycle pulse per key on a debounced 0→1 transition.
- `key_edge`  out  4  sticky press-capture flags (macro-dependent).
- `edge_clear`  in  4  per-bit clear of `key_edge`, sampled each cycle.
- `irq_mask`  in  4  per-bit interrupt enable.
- `irq`  out  1  registered interrupt request.

## Operation
- 14 independent channels: keys 0–3 use the input `~key_n`; switches 0–9 use the input `sw`.
- Each channel has a two-flop synchroniser (`s1`→`s2`), a stable register, and a `CNT_W`-bit counter.
- Per channel, every cycle:
  - If `s2 == stable`, the counter is set to 0.
  - Otherwise, if `counter == DEBOUNCE_CYCLES-1`, `stable <= s2` and the counter is set to 0.
  - Otherwise the counter increments.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never reaches `stable`. Any return to the stable level restarts the count from 0.
- The counter never wraps: its maximum value is `DEBOUNCE_CYCLES-1`.
- `pushbuttons_export` and `slider_switches_export` are the channel `stable` registers.
- `key_press[i]` is registered, asserted for the single cycle after the key's `stable` goes 0→1. A 1→0 transition produces no pulse.
- `key_edge[i]`:
  - Set to 1 in the same cycle that `key_press[i]` asserts.
  - Cleared by `edge_clear[i]=1`.
  - If set and clear occur in the same cycle, set wins.
- `irq` is registered as `|(key_edge & irq_mask)`, so it lags `key_edge` by one cycle.

## Timing
- Reset values:
  - All `s1`/`s2` registers take the released/inactive level: 0 after the key inversion, 0 for switches.
  - All `stable` registers, counters, `key_press`, `key_edge` and `irq` are 0.
- Latency: let edge N be the first clock edge that samples a new, held input level into `s1`.
  - `stable` (and therefore the export output) updates on edge N+DEBOUNCE_CYCLES+1.
  - `key_press` pulses on edge N+DEBOUNCE_CYCLES+2.
  - `key_edge` sets on edge N+DEBOUNCE_CYCLES+2.
  - `irq` asserts on edge N+DEBOUNCE_CYCLES+3.
- `edge_clear` takes effect on the next edge. `irq` falls one edge after that.
- Reset asserted mid-count: all state returns to its reset value on that edge with no pulses. After reset releases, a held input takes the full latency again.
- Simultaneous presses on several keys produce simultaneous independent pulses and flags.

## Configuration
- `INPUT_COND_EDGE_IRQ_EN` defined: `key_edge` and `irq` logic are built as described above.
- Not defined: `key_edge` is tied to 4'b0 and `irq` is tied to 0. `edge_clear` and `irq_mask` are ignored and no registers are instantiated for them. The debounce logic, exports and `key_press` are unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- Reset, then hold `key_n=4'hF`, `sw=0` → all outputs stay 0. Assert `reset` during a count → counters clear and no pulse occurs.
- `key_n[0]` goes 1→0 at edge N and is held → `pushbuttons_export=4'h1` at edge N+5, `key_press=4'h1` for exactly one cycle at edge N+6, and `key_edge[0]=1`. With `irq_mask=4'h1`, `irq=1` at edge N+7.
- `sw[9]` pulse 3 cycles wide, then a pulse 4 cycles wide → the 3-cycle pulse is filtered out. The 4-cycle pulse sets `slider_switches_export[9]=1` at edge N+5.
- `sw[3]` toggles every 2 cycles for 40 cycles → `slider_switches_export[3]` never changes.
- `key_edge[2]` set, then `edge_clear[2]=1` asserted in the same cycle as a new `key_press[2]` → `key_edge[2]` stays 1. `edge_clear` alone on the next cycle → `key_edge[2]=0` and `irq` falls one cycle later.
- Build without the macro and repeat the press scenario → `key_press` pulse is unchanged, while `key_edge` and `irq` stay 0 throughout.
